// File: rtl/sdr_lib_pkg.sv
// Shared definitions for the strobe-arbiter slice: channel geometry, FSM
// encoding and the round-robin search helper.
package sdr_lib;

  localparam int NCHAN = 4;
  localparam int RW    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // First set request at or after ptr, wrapping mod NCHAN; the descending
  // loop lets the smallest offset from ptr overwrite the others.
  function automatic logic [1:0] rrPick(input logic [NCHAN-1:0] req,
                                        input logic [1:0]       ptr);
    logic [1:0] idx;
    rrPick = ptr;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rrPick = idx;
    end
  endfunction

endpackage

// File: rtl/chan_strobe_arbiter_rate_strobe.sv
// Per-channel period counter: strobes once every rate+1 cycles while enabled.
module rate_strobe
  import sdr_lib::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [RW-1:0] rate,
  output logic          strobe
);

  logic [RW-1:0] count;

  // A rate lowered below the current count lets the counter run on to the
  // natural overflow, after which it compares against the new rate.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == rate) begin
      count <= '0;
    end else begin
      count <= count + RW'(1);
    end
  end

  assign strobe = enable && (count == rate);

endmodule

// File: rtl/chan_strobe_arbiter.sv
// Collects per-channel rate strobes into single-depth requests and launches
// the shared datapath on them one at a time in round-robin order.
module chan_strobe_arbiter
  import sdr_lib::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [NCHAN-1:0]    enable,
  input  logic [NCHAN*RW-1:0] rate,
  input  logic                done,
  input  logic                ovr_clear,
  output logic                start,
  output logic [1:0]          grant_chan,
  output logic                busy,
  output logic [NCHAN-1:0]    pending,
  output logic [NCHAN-1:0]    overrun
);

  arb_state_t       state;
  arb_state_t       stateNext;
  logic [NCHAN-1:0] strobe;
  logic [NCHAN-1:0] startVec;
  logic [NCHAN-1:0] pendingNext;
  logic [NCHAN-1:0] overrunNext;
  logic [1:0]       rrPtr;
  logic [1:0]       lastGrant;
  logic [1:0]       pick;

  for (genvar i = 0; i < NCHAN; i++) begin : gChan
    rate_strobe uStrobe (
      .clock  (clock),
      .reset  (reset),
      .enable (enable[i]),
      .rate   (rate[i*RW +: RW]),
      .strobe (strobe[i])
    );
  end

  // Launch decision works only from registered pending, so start never
  // depends combinationally on this cycle's inputs.
  always_comb begin
    stateNext = state;
    start     = 1'b0;
    startVec  = '0;
    pick      = rrPick(pending, rrPtr);
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          start          = 1'b1;
          startVec[pick] = 1'b1;
          stateNext      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy       = (state == ST_BUSY);
  assign grant_chan = start ? pick : lastGrant;

  // A strobe landing on the same cycle its channel is launched re-arms the
  // request instead of counting as lost.
  always_comb begin
    pendingNext = pending;
    overrunNext = ovr_clear ? '0 : overrun;
    for (int i = 0; i < NCHAN; i++) begin
      if (!enable[i]) begin
        pendingNext[i] = 1'b0;
      end else if (strobe[i]) begin
        pendingNext[i] = 1'b1;
        if (pending[i] && !startVec[i]) overrunNext[i] = 1'b1;
      end else if (startVec[i]) begin
        pendingNext[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      pending   <= '0;
      overrun   <= '0;
      rrPtr     <= '0;
      lastGrant <= '0;
    end else begin
      state   <= stateNext;
      pending <= pendingNext;
      overrun <= overrunNext;
      if (start) begin
        lastGrant <= pick;
        rrPtr     <= pick + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_chan_strobe_arbiter.sv
// Directed bench for chan_strobe_arbiter: a cycle table for the single-channel
// case plus hand-timed sequences for the multi-cycle corners.
module tb_chan_strobe_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  enable = '0;
  logic [31:0] rate = '0;
  logic        done = 1'b0;
  logic        ovr_clear = 1'b0;
  logic        start;
  logic [1:0]  grant_chan;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  overrun;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  chan_strobe_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .done       (done),
    .ovr_clear  (ovr_clear),
    .start      (start),
    .grant_chan (grant_chan),
    .busy       (busy),
    .pending    (pending),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] rt;
    logic        dn;
    logic        oc;
    logic        eStart;
    logic [1:0]  eGrant;
    logic        eBusy;
    logic [3:0]  ePend;
    logic [3:0]  eOvr;
  } vec_t;

  vec_t vecs[13];

  // Outputs of the current cycle are compared at its falling edge.
  task automatic checkOutput(input string name, input logic eStart,
                             input logic [1:0] eGrant, input logic eBusy,
                             input logic [3:0] ePend, input logic [3:0] eOvr);
    total++;
    if ({start, grant_chan, busy, pending, overrun} !== {eStart, eGrant, eBusy, ePend, eOvr}) begin
      bad++;
      $display("[TB] FAIL %s: got start=%0b grant=%0d busy=%0b pending=%b overrun=%b, want start=%0b grant=%0d busy=%0b pending=%b overrun=%b",
               name, start, grant_chan, busy, pending, overrun, eStart, eGrant, eBusy, ePend, eOvr);
    end
  endtask

  // Drive this cycle's inputs, then move on to the next falling edge.
  task automatic applyStimulus(input logic [3:0] en, input logic [31:0] rt,
                               input logic dn, input logic oc);
    enable    = en;
    rate      = rt;
    done      = dn;
    ovr_clear = oc;
    @(negedge clock);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    enable    = '0;
    done      = 1'b0;
    ovr_clear = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001, 32'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0001, 32'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[9]  = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0001, 32'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0001, 32'h3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000};

    @(negedge clock);

    // ch0 alone at rate 3, done two cycles after each start.
    doReset();
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("ch0_vec%0d", i), vecs[i].eStart, vecs[i].eGrant,
                  vecs[i].eBusy, vecs[i].ePend, vecs[i].eOvr);
      applyStimulus(vecs[i].en, vecs[i].rt, vecs[i].dn, vecs[i].oc);
    end

    // All four channels aligned at rate 15: grants sweep 0..3.
    doReset();
    checkOutput("rr_reset", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    for (int c = 0; c < 16; c++) applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b0, 1'b0);
    checkOutput("rr_ch0", 1'b1, 2'd0, 1'b0, 4'b1111, 4'b0000);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b0, 1'b0);
    checkOutput("rr_busy0", 1'b0, 2'd0, 1'b1, 4'b1110, 4'b0000);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b1, 1'b0);
    checkOutput("rr_ch1", 1'b1, 2'd1, 1'b0, 4'b1110, 4'b0000);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b0, 1'b0);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b1, 1'b0);
    checkOutput("rr_ch2", 1'b1, 2'd2, 1'b0, 4'b1100, 4'b0000);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b0, 1'b0);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b1, 1'b0);
    checkOutput("rr_ch3", 1'b1, 2'd3, 1'b0, 4'b1000, 4'b0000);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b0, 1'b0);
    applyStimulus(4'b1111, 32'h0F0F0F0F, 1'b1, 1'b0);
    checkOutput("rr_drained", 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000);

    // ch2 at rate 2 with a slow datapath: overrun, clear, and clear-vs-set.
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    checkOutput("ovr_start", 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    checkOutput("ovr_busy", 1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000);
    for (int c = 4; c < 9; c++) applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    checkOutput("ovr_set", 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b1);
    checkOutput("ovr_cleared", 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0000);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b1);
    checkOutput("ovr_set_wins", 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 32'h00020000, 1'b1, 1'b0);
    checkOutput("ovr_restart", 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0100);
    applyStimulus(4'b0100, 32'h00020000, 1'b0, 1'b0);
    checkOutput("ovr_rearmed", 1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100);

    // ch1 at rate 0: strobe every cycle, start every other cycle.
    doReset();
    checkOutput("r0_reset", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 32'h0, 1'b0, 1'b0);
    checkOutput("r0_start1", 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 32'h0, 1'b0, 1'b0);
    checkOutput("r0_busy1", 1'b0, 2'd1, 1'b1, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 32'h0, 1'b1, 1'b0);
    checkOutput("r0_start2", 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0010);
    applyStimulus(4'b0010, 32'h0, 1'b0, 1'b0);
    checkOutput("r0_busy2", 1'b0, 2'd1, 1'b1, 4'b0010, 4'b0010);
    applyStimulus(4'b0010, 32'h0, 1'b1, 1'b0);
    checkOutput("r0_start3", 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0010);

    // Reset while busy on ch1, then a stray done.
    doReset();
    for (int c = 0; c < 4; c++) applyStimulus(4'b0010, 32'h00000300, 1'b0, 1'b0);
    checkOutput("rst_start", 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 32'h00000300, 1'b0, 1'b0);
    checkOutput("rst_busy", 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000);
    reset = 1'b1;
    applyStimulus(4'b0010, 32'h00000300, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_cleared", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 32'h00000300, 1'b1, 1'b0);
    for (int c = 7; c < 10; c++) begin
      checkOutput($sformatf("rst_quiet%0d", c), 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
      applyStimulus(4'b0010, 32'h00000300, 1'b0, 1'b0);
    end
    checkOutput("rst_restart", 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000);

    // ch3 request withdrawn while ch0 busy; pointer must still follow ch0.
    doReset();
    for (int c = 0; c < 16; c++) applyStimulus(4'b1101, 32'h101F000F, 1'b0, 1'b0);
    checkOutput("wd_ch0", 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000);
    applyStimulus(4'b1101, 32'h101F000F, 1'b0, 1'b0);
    checkOutput("wd_ch3_pend", 1'b0, 2'd0, 1'b1, 4'b1000, 4'b0000);
    applyStimulus(4'b0101, 32'h101F000F, 1'b0, 1'b0);
    checkOutput("wd_ch3_drop", 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(4'b0101, 32'h101F000F, 1'b0, 1'b0);
    applyStimulus(4'b0101, 32'h101F000F, 1'b1, 1'b0);
    for (int c = 20; c < 32; c++) begin
      checkOutput($sformatf("wd_idle%0d", c), 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
      applyStimulus(4'b0101, 32'h101F000F, 1'b0, 1'b0);
    end
    checkOutput("wd_ptr", 1'b1, 2'd2, 1'b0, 4'b0101, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
